// File: rtl/sdram_burst_arbiter.sv
// Purpose: shares one memory-controller command port between a write-burst source and a read-burst sink, round-robin per burst.
// Latency: grant/cmd_en one cycle after req is sampled; read beats forwarded one cycle after mem_rd_data_valid.
// Backpressure: none on data; requesters hold req until their grant pulse, then the burst runs to completion or read timeout.
module sdram_burst_arbiter #(
    parameter int ADDR_WIDTH     = 21,
    parameter int DATA_WIDTH     = 32,
    parameter int BURST          = 32,
    parameter int RECOVER_CYCLES = 4,   // must be >= 1
    parameter int RD_TIMEOUT     = 256
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  init_done,
    output logic                  mem_cmd,
    output logic                  mem_cmd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  mem_rd_data_valid,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  wr_gnt,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_data_rd,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_gnt,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    output logic                  busy,
    output logic                  error
);

    localparam int BEAT_W = $clog2(BURST + 1);
    localparam int TO_W   = $clog2(RD_TIMEOUT + 1);
    localparam int REC_W  = $clog2(RECOVER_CYCLES + 1);

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(RD_TIMEOUT - 1);
    localparam logic [REC_W-1:0]  REC_LAST  = REC_W'(RECOVER_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_WAIT, RECOVER} state_t;

    state_t                state_q;
    logic                  last_wr_q;      // 1: write was served last, 0: read
    logic [BEAT_W-1:0]     beat_q;
    logic [TO_W-1:0]       to_q;
    logic [REC_W-1:0]      rec_q;
    logic                  cmd_q;
    logic                  cmd_en_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  wr_gnt_q;
    logic                  rd_gnt_q;
    logic                  wr_rd_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;
    logic                  busy_q;
    logic                  error_q;

    logic grant_wr_d;
    logic grant_rd_d;

    // Round-robin pick: a lone request wins; on a tie the side not served last wins.
    assign grant_wr_d = init_done && wr_req && (!rd_req || !last_wr_q);
    assign grant_rd_d = init_done && rd_req && !grant_wr_d;

    // Burst sequencer: grant, stream beats, enforce recovery gap, track protocol errors.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            last_wr_q  <= 1'b0;
            beat_q     <= '0;
            to_q       <= '0;
            rec_q      <= '0;
            cmd_q      <= 1'b0;
            cmd_en_q   <= 1'b0;
            addr_q     <= '0;
            wr_gnt_q   <= 1'b0;
            rd_gnt_q   <= 1'b0;
            wr_rd_q    <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            cmd_en_q   <= 1'b0;
            wr_gnt_q   <= 1'b0;
            rd_gnt_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            // Read beats are only expected while a read is outstanding.
            if (mem_rd_data_valid && state_q != RD_WAIT) begin
                error_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (grant_wr_d) begin
                        wr_gnt_q  <= 1'b1;
                        cmd_en_q  <= 1'b1;
                        cmd_q     <= 1'b1;
                        addr_q    <= wr_addr;
                        wr_rd_q   <= 1'b1;
                        beat_q    <= '0;
                        last_wr_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= WR_BURST;
                    end else if (grant_rd_d) begin
                        rd_gnt_q  <= 1'b1;
                        cmd_en_q  <= 1'b1;
                        cmd_q     <= 1'b0;
                        addr_q    <= rd_addr;
                        beat_q    <= '0;
                        to_q      <= '0;
                        last_wr_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= RD_WAIT;
                    end
                end
                WR_BURST: begin
                    if (beat_q == BEAT_LAST) begin
                        wr_rd_q <= 1'b0;
                        rec_q   <= '0;
                        state_q <= RECOVER;
                    end else begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                RD_WAIT: begin
                    to_q <= to_q + 1'b1;
                    if (mem_rd_data_valid) begin
                        rd_data_q  <= mem_rd_data;
                        rd_valid_q <= 1'b1;
                        beat_q     <= beat_q + 1'b1;
                    end
                    // A beat landing on the final timeout cycle still completes the burst cleanly.
                    if (mem_rd_data_valid && beat_q == BEAT_LAST) begin
                        rec_q   <= '0;
                        state_q <= RECOVER;
                    end else if (to_q == TO_LAST) begin
                        error_q <= 1'b1;
                        rec_q   <= '0;
                        state_q <= RECOVER;
                    end
                end
                RECOVER: begin
                    if (rec_q == REC_LAST) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        rec_q <= rec_q + 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_cmd     = cmd_q;
    assign mem_cmd_en  = cmd_en_q;
    assign mem_addr    = addr_q;
    // Writer source is first-word-fall-through, so its head word is valid in the same cycle as the advance strobe.
    assign mem_wr_data = wr_rd_q ? wr_data : '0;
    assign wr_gnt      = wr_gnt_q;
    assign wr_data_rd  = wr_rd_q;
    assign rd_gnt      = rd_gnt_q;
    assign rd_data_o   = rd_data_q;
    assign rd_valid_o  = rd_valid_q;
    assign busy        = busy_q;
    assign error       = error_q;

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Purpose: directed bench for sdram_burst_arbiter with a FWFT write source and a fixed-latency read responder.
// Latency: responder returns beats 10 cycles after a read cmd_en.
// Backpressure: none; requests are held until granted.
module tb_sdram_burst_arbiter;

    localparam int AW = 21;
    localparam int DW = 32;
    localparam logic [DW-1:0] RD_BASE = 32'hA5A5_0000;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          init_done;
    logic          mem_cmd;
    logic          mem_cmd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data;
    logic [DW-1:0] mem_rd_data;
    logic          mem_rd_data_valid;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic          wr_gnt;
    logic [DW-1:0] wr_data;
    logic          wr_data_rd;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_gnt;
    logic [DW-1:0] rd_data_o;
    logic          rd_valid_o;
    logic          busy;
    logic          error;

    int n_vec = 0;
    int n_err = 0;
    int model_beats = 32;
    logic [DW-1:0] wr_cnt;

    always #5 clk = ~clk;

    sdram_burst_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST(32), .RECOVER_CYCLES(4), .RD_TIMEOUT(256)
    ) dut (
        .clk(clk), .reset_n(reset_n), .init_done(init_done),
        .mem_cmd(mem_cmd), .mem_cmd_en(mem_cmd_en), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
        .mem_rd_data_valid(mem_rd_data_valid),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_gnt(wr_gnt), .wr_data(wr_data),
        .wr_data_rd(wr_data_rd), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .busy(busy), .error(error)
    );

    // FWFT writer source: head word is a running count, popped on each wr_data_rd cycle.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) wr_cnt <= '0;
        else if (wr_data_rd) wr_cnt <= wr_cnt + 1;
    end
    assign wr_data = wr_cnt;

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Read responder: 10 cycles after a read cmd_en, return model_beats consecutive beats.
    initial begin
        mem_rd_data_valid = 1'b0;
        mem_rd_data       = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset_n && mem_cmd_en && !mem_cmd) begin
                for (int w = 0; w < 10; w++) begin
                    @(posedge clk);
                    #1;
                end
                for (int b = 0; b < model_beats; b++) begin
                    mem_rd_data_valid = 1'b1;
                    mem_rd_data       = RD_BASE + 32'(b);
                    @(posedge clk);
                    #1;
                end
                mem_rd_data_valid = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    initial begin
        int hits, bad, nb, first, n, ncmd, last_end, min_gap, gnt_bad, cmd_cnt;
        logic [3:0] order;

        reset_n = 1'b0; init_done = 1'b0;
        wr_req = 1'b0; rd_req = 1'b0; wr_addr = '0; rd_addr = '0;
        ticks(2);
        expect_eq("rst_cmd_en",  64'(mem_cmd_en), 64'd0);
        expect_eq("rst_cmd",     64'(mem_cmd), 64'd0);
        expect_eq("rst_addr",    64'(mem_addr), 64'd0);
        expect_eq("rst_gnts",    64'({wr_gnt, rd_gnt}), 64'd0);
        expect_eq("rst_wr_rd",   64'(wr_data_rd), 64'd0);
        expect_eq("rst_wr_data", 64'(mem_wr_data), 64'd0);
        expect_eq("rst_rd_out",  64'({rd_valid_o, rd_data_o}), 64'd0);
        expect_eq("rst_busy",    64'(busy), 64'd0);
        expect_eq("rst_error",   64'(error), 64'd0);

        // No grant while the controller is uncalibrated.
        reset_n = 1'b1; wr_req = 1'b1; wr_addr = 21'h00100;
        hits = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (mem_cmd_en || wr_gnt || busy) hits++;
        end
        expect_eq("init_low_no_grant", 64'(hits), 64'd0);

        // Calibration done: write grant appears one cycle later.
        init_done = 1'b1;
        tick();
        expect_eq("wr_gnt",      64'(wr_gnt), 64'd1);
        expect_eq("wr_cmd_en",   64'(mem_cmd_en), 64'd1);
        expect_eq("wr_cmd",      64'(mem_cmd), 64'd1);
        expect_eq("wr_addr",     64'(mem_addr), 64'h00100);
        expect_eq("wr_no_rdgnt", 64'(rd_gnt), 64'd0);
        wr_req = 1'b0;
        bad = 0; cmd_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            if (!wr_data_rd || mem_wr_data !== 32'(i)) bad++;
            if (mem_cmd_en) cmd_cnt++;
            tick();
        end
        expect_eq("wr_beat_seq",     64'(bad), 64'd0);
        expect_eq("wr_cmd_en_pulse", 64'(cmd_cnt), 64'd1);
        expect_eq("wr_rd_drops",     64'(wr_data_rd), 64'd0);
        expect_eq("wr_data_zero",    64'(mem_wr_data), 64'd0);
        expect_eq("wr_pop_count",    64'(wr_cnt), 64'd32);
        expect_eq("wr_busy_recover", 64'(busy), 64'd1);
        ticks(3);
        expect_eq("wr_busy_c35", 64'(busy), 64'd1);
        tick();
        expect_eq("wr_busy_c36", 64'(busy), 64'd0);

        // Single read; beats come back 10 cycles after cmd_en.
        rd_addr = 21'h00200; rd_req = 1'b1;
        tick();
        expect_eq("rd_gnt",      64'(rd_gnt), 64'd1);
        expect_eq("rd_cmd_en",   64'(mem_cmd_en), 64'd1);
        expect_eq("rd_cmd",      64'(mem_cmd), 64'd0);
        expect_eq("rd_addr",     64'(mem_addr), 64'h00200);
        expect_eq("rd_no_wrgnt", 64'(wr_gnt), 64'd0);
        rd_req = 1'b0;
        nb = 0; first = -1; bad = 0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (rd_valid_o) begin
                if (first < 0) first = k;
                if (rd_data_o !== RD_BASE + 32'(nb)) bad++;
                nb++;
            end
        end
        expect_eq("rd_first_beat", 64'(first), 64'd11);
        expect_eq("rd_beat_count", 64'(nb), 64'd32);
        expect_eq("rd_beat_data",  64'(bad), 64'd0);
        expect_eq("rd_error",      64'(error), 64'd0);
        expect_eq("rd_busy_done",  64'(busy), 64'd0);

        // Both requesters saturated: strict alternation starting with write.
        wr_req = 1'b1; rd_req = 1'b1; wr_addr = 21'h00140; rd_addr = 21'h00240;
        ncmd = 0; last_end = -1; min_gap = 1000; gnt_bad = 0; order = '0;
        for (int k = 0; k < 400 && ncmd < 4; k++) begin
            tick();
            if (mem_cmd_en) begin
                order[ncmd] = mem_cmd;
                if (mem_cmd ? !wr_gnt : !rd_gnt) gnt_bad++;
                if (last_end >= 0 && (k - last_end - 1) < min_gap) min_gap = k - last_end - 1;
                ncmd++;
                if (ncmd == 4) begin
                    wr_req = 1'b0; rd_req = 1'b0;
                end
            end
            if (wr_data_rd || mem_rd_data_valid) last_end = k;
        end
        expect_eq("alt_cmd_count", 64'(ncmd), 64'd4);
        expect_eq("alt_order",     64'(order), 64'b0101);
        expect_eq("alt_gnt_match", 64'(gnt_bad), 64'd0);
        expect_eq("alt_gap_ge4",   64'(min_gap >= 4), 64'd1);
        n = 0;
        while (busy && n < 200) begin tick(); n++; end
        expect_eq("alt_idle",  64'(busy), 64'd0);
        expect_eq("alt_error", 64'(error), 64'd0);

        // Short read: timeout flags error exactly 256 cycles after cmd_en.
        model_beats = 20; rd_addr = 21'h00280; rd_req = 1'b1;
        tick();
        expect_eq("to_cmd_en", 64'({mem_cmd_en, mem_cmd}), 64'b10);
        rd_req = 1'b0;
        ticks(255);
        expect_eq("to_not_yet", 64'(error), 64'd0);
        tick();
        expect_eq("to_error", 64'(error), 64'd1);
        expect_eq("to_busy",  64'(busy), 64'd1);
        wr_req = 1'b1; wr_addr = 21'h00300;
        n = 0;
        while (!wr_gnt && n < 50) begin tick(); n++; end
        expect_eq("to_next_wr_gnt",  64'(wr_gnt), 64'd1);
        expect_eq("to_next_latency", 64'(n), 64'd5);
        expect_eq("to_next_addr",    64'(mem_addr), 64'h00300);
        wr_req = 1'b0;
        n = 0;
        while (busy && n < 100) begin tick(); n++; end
        expect_eq("to_wr_done", 64'(busy), 64'd0);

        // Reset clears the sticky error.
        model_beats = 32;
        reset_n = 1'b0;
        #1;
        expect_eq("rst_clears_error", 64'(error), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Stray read beat while idle.
        mem_rd_data_valid = 1'b1; mem_rd_data = 32'h0000_DEAD;
        tick();
        mem_rd_data_valid = 1'b0;
        expect_eq("stray_no_valid", 64'(rd_valid_o), 64'd0);
        expect_eq("stray_error",    64'(error), 64'd1);

        // Asynchronous reset in the middle of a write burst.
        wr_req = 1'b1; wr_addr = 21'h003C0;
        n = 0;
        while (!wr_gnt && n < 20) begin tick(); n++; end
        expect_eq("mid_wr_gnt", 64'(wr_gnt), 64'd1);
        wr_req = 1'b0;
        ticks(10);
        expect_eq("mid_wr_active", 64'(wr_data_rd), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        expect_eq("arst_wr_rd",   64'(wr_data_rd), 64'd0);
        expect_eq("arst_wr_data", 64'(mem_wr_data), 64'd0);
        expect_eq("arst_cmd",     64'({mem_cmd_en, mem_cmd, wr_gnt, rd_gnt}), 64'd0);
        expect_eq("arst_addr",    64'(mem_addr), 64'd0);
        expect_eq("arst_busy",    64'(busy), 64'd0);
        expect_eq("arst_error",   64'(error), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
